// File: rtl/run_pattern_gen_if.sv
// Request/serial-output bundle between test/control logic and the run pattern generator.
// The master side issues run requests; the slave side (the generator) drives the stream.
interface run_pattern_gen_if #(
    parameter int LEN_W = 4
);
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic             abort_i;
    logic             ready_o;
    logic             x_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, len_i, abort_i,
        input  ready_o, x_o, busy_o, done_o
    );

    modport slave (
        input  start_i, len_i, abort_i,
        output ready_o, x_o, busy_o, done_o
    );
endinterface

// File: rtl/run_pattern_gen.sv
// Serial run-length transmitter: on request emits len consecutive 1s on x_o,
// then GAP_CYC 0s, pulsing done_o in the last gap cycle.
//
// state | meaning
// IDLE  | waiting for start_i with nonzero len_i; ready_o=1
// ONES  | driving x_o=1, run counter counts the latched length down
// GAP   | driving x_o=0 for GAP_CYC cycles; done_o in the final one
module run_pattern_gen #(
    parameter int LEN_W   = 4,
    parameter int GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    run_pattern_gen_if.slave  bus
);
    // Extra headroom so the gap counter can always hold GAP_CYC and compare against 2.
    localparam int GW = $clog2(GAP_CYC + 2);
    localparam logic [GW-1:0]    GAP_LOAD      = GW'(GAP_CYC);
    localparam logic [GW-1:0]    GAP_ONE       = GW'(1);
    localparam logic [GW-1:0]    GAP_TWO       = GW'(2);
    localparam logic [LEN_W-1:0] RUN_ONE       = LEN_W'(1);
    localparam logic             LAST_ON_ENTRY = (GAP_CYC == 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ONES = 2'b01,
        GAP  = 2'b10
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] run_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             x_q;
    logic             busy_q;
    logic             ready_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            run_cnt <= '0;
            gap_cnt <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i && (bus.len_i != '0)) begin
                        state   <= ONES;
                        run_cnt <= bus.len_i;
                        x_q     <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                ONES: begin
                    // The counter holds the number of 1s still owed including the current one.
                    if (bus.abort_i || (run_cnt == RUN_ONE)) begin
                        state   <= GAP;
                        run_cnt <= '0;
                        gap_cnt <= GAP_LOAD;
                        x_q     <= 1'b0;
                        done_q  <= LAST_ON_ENTRY;
                    end else begin
                        run_cnt <= run_cnt - RUN_ONE;
                    end
                end
                GAP: begin
                    if (gap_cnt <= GAP_ONE) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                        done_q  <= (gap_cnt == GAP_TWO);
                    end
                end
                default: begin
                    state   <= IDLE;
                    run_cnt <= '0;
                    gap_cnt <= '0;
                    x_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.x_o     = x_q;
    assign bus.busy_o  = busy_q;
    assign bus.ready_o = ready_q;
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_run_pattern_gen.sv
// Self-checking bench for run_pattern_gen: a run/gap count model checked every cycle
// on two instances (GAP_CYC=1 and 3), plus literal waveform checks for directed scenarios.
module tb_run_pattern_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    run_pattern_gen_if #(.LEN_W(4)) if1 ();
    run_pattern_gen_if #(.LEN_W(4)) if3 ();

    run_pattern_gen #(.LEN_W(4), .GAP_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    run_pattern_gen #(.LEN_W(4), .GAP_CYC(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Model: 1s still owed and 0s still owed for each instance.
    int   ones_left[2];
    int   gap_left[2];
    logic st[2], ab[2];
    logic [3:0] ln[2];
    logic ax[2], ad[2], abz[2], ar[2];

    assign st[0] = if1.start_i;  assign st[1] = if3.start_i;
    assign ab[0] = if1.abort_i;  assign ab[1] = if3.abort_i;
    assign ln[0] = if1.len_i;    assign ln[1] = if3.len_i;
    assign ax[0] = if1.x_o;      assign ax[1] = if3.x_o;
    assign ad[0] = if1.done_o;   assign ad[1] = if3.done_o;
    assign abz[0] = if1.busy_o;  assign abz[1] = if3.busy_o;
    assign ar[0] = if1.ready_o;  assign ar[1] = if3.ready_o;

    function automatic int gap_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ones_left[i] <= 0;
                gap_left[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ones_left[i] > 0)
                    ones_left[i] <= ab[i] ? 0 : ones_left[i] - 1;
                else if (gap_left[i] > 0)
                    gap_left[i] <= gap_left[i] - 1;
                else if (st[i] && ln[i] != 4'd0) begin
                    ones_left[i] <= int'(ln[i]);
                    gap_left[i]  <= gap_of(i);
                end
            end
        end
    end

    // Per-cycle compare, plus a falling-edge run detector on the GAP_CYC=1 stream.
    int   y_cnt = 0, done_cnt = 0, ones_cnt = 0;
    logic prev_x1 = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("x_o[%0d]", i),     int'(ax[i]),  int'(ones_left[i] > 0));
            chk($sformatf("done_o[%0d]", i),  int'(ad[i]),  int'(ones_left[i] == 0 && gap_left[i] == 1));
            chk($sformatf("busy_o[%0d]", i),  int'(abz[i]), int'(ones_left[i] + gap_left[i] > 0));
            chk($sformatf("ready_o[%0d]", i), int'(ar[i]),  int'(ones_left[i] + gap_left[i] == 0));
        end
        if (prev_x1 && !if1.x_o) y_cnt <= y_cnt + 1;
        if (if1.done_o)          done_cnt <= done_cnt + 1;
        if (if1.x_o)             ones_cnt <= ones_cnt + 1;
        prev_x1 <= if1.x_o;
    end

    task automatic drive1(logic s, int l, logic a);
        if1.start_i = s;
        if1.len_i   = 4'(l);
        if1.abort_i = a;
    endtask

    task automatic wait_ready1();
        int k = 0;
        while (!if1.ready_o && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (!if1.ready_o) chk("ready_timeout", 0, 1);
    endtask

    // Returns at the negedge of the first output cycle after the accepting edge.
    task automatic issue1(int l, logic a);
        wait_ready1();
        drive1(1'b1, l, a);
        @(negedge clk);
        drive1(1'b0, 0, 1'b0);
    endtask

    task automatic samp1(inout int xs, inout int ds, inout int rs);
        xs = (xs << 1) | int'(if1.x_o);
        ds = (ds << 1) | int'(if1.done_o);
        rs = (rs << 1) | int'(if1.ready_o);
    endtask

    task automatic collect1(int n, output int xs, output int ds, output int rs);
        xs = 0; ds = 0; rs = 0;
        for (int i = 0; i < n; i++) begin
            samp1(xs, ds, rs);
            @(negedge clk);
        end
    endtask

    int lens[15] = '{4, 1, 15, 9, 2, 12, 7, 3, 14, 5, 11, 6, 13, 8, 10};

    initial begin
        int xs, ds, rs;
        int b_y, b_d, b_o;
        drive1(1'b0, 0, 1'b0);
        if3.start_i = 1'b0; if3.len_i = 4'd0; if3.abort_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(if1.ready_o), 1);
        chk("rst_x",     int'(if1.x_o),     0);
        chk("rst_busy",  int'(if1.busy_o),  0);
        chk("rst_done",  int'(if1.done_o),  0);
        rst_n = 1'b1;
        @(negedge clk);

        // len=3, one gap cycle
        issue1(3, 1'b0);
        collect1(5, xs, ds, rs);
        chk("len3_x",     xs, 'b11100);
        chk("len3_done",  ds, 'b00010);
        chk("len3_ready", rs, 'b00001);

        // len=0 request is ignored
        issue1(0, 1'b0);
        collect1(3, xs, ds, rs);
        chk("len0_x",     xs, 'b000);
        chk("len0_done",  ds, 'b000);
        chk("len0_ready", rs, 'b111);

        // len=5 aborted on the 2nd 1; start pulses while busy are ignored
        issue1(5, 1'b0);
        xs = 0; ds = 0; rs = 0;
        samp1(xs, ds, rs); @(negedge clk);
        samp1(xs, ds, rs); drive1(1'b1, 9, 1'b1); @(negedge clk);
        samp1(xs, ds, rs); drive1(1'b1, 9, 1'b0); @(negedge clk);
        samp1(xs, ds, rs); drive1(1'b0, 0, 1'b0); @(negedge clk);
        samp1(xs, ds, rs);
        chk("abort_x",     xs, 'b11000);
        chk("abort_done",  ds, 'b00100);
        chk("abort_ready", rs, 'b00011);
        @(negedge clk);

        // abort together with acceptance in IDLE: start wins
        issue1(2, 1'b1);
        collect1(4, xs, ds, rs);
        chk("acc_abort_x",    xs, 'b1100);
        chk("acc_abort_done", ds, 'b0010);

        // reset in the middle of a len=7 run
        issue1(7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_pre_x", int'(if1.x_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_x",     int'(if1.x_o),     0);
        chk("rst_mid_ready", int'(if1.ready_o), 1);
        chk("rst_mid_busy",  int'(if1.busy_o),  0);
        chk("rst_mid_done",  int'(if1.done_o),  0);
        @(negedge clk);
        chk("rst_hold_done", int'(if1.done_o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        issue1(2, 1'b0);
        collect1(4, xs, ds, rs);
        chk("post_rst_x",    xs, 'b1100);
        chk("post_rst_done", ds, 'b0010);

        // len=15 with GAP_CYC=3, then a start held for the next possible acceptance
        if3.start_i = 1'b1; if3.len_i = 4'd15;
        @(negedge clk);
        if3.len_i = 4'd4;
        xs = 0; ds = 0; rs = 0;
        for (int i = 0; i < 26; i++) begin
            xs = (xs << 1) | int'(if3.x_o);
            ds = (ds << 1) | int'(if3.done_o);
            rs = (rs << 1) | int'(if3.ready_o);
            if (i == 19) if3.start_i = 1'b0;
            @(negedge clk);
        end
        chk("max_len_x",     xs, 26'b111111111111111_0000_1111_000);
        chk("max_len_done",  ds, 26'b00000000000000000_1_0000000_1);
        chk("max_len_ready", rs, 26'b000000000000000000_1_0000000);

        // loopback: one detector event per done_o
        b_y = y_cnt; b_d = done_cnt; b_o = ones_cnt;
        foreach (lens[i]) begin
            issue1(lens[i], 1'b0);
            wait_ready1();
        end
        repeat (2) @(negedge clk);
        chk("loop_y_vs_done", y_cnt - b_y, done_cnt - b_d);
        chk("loop_done_cnt",  done_cnt - b_d, 15);
        chk("loop_ones_cnt",  ones_cnt - b_o, 120);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
